// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and active-low hex segment table for the 7-segment scan driver.
package seg7_pkg;
    localparam int DEFAULT_NUM_DIGITS = 4;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble to active-low g..a segment lookup.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = HEX_SEG[nib];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed hex display driver with frame-latched value.
// Optional SEG7_LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always lit).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = DEFAULT_NUM_DIGITS,
    parameter int USE_INT_TICK = 0,
    parameter int TICK_DIV     = 17
) (
    input  logic                    clk,
    input  logic                    clr_n,
    input  logic                    scan_clk,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
    logic tick;
    generate
        if (USE_INT_TICK != 0) begin : g_int
            logic [TICK_DIV-1:0] cnt;
            always_ff @(posedge clk) cnt <= clr_n ? cnt + 1'b1 : '0;
            assign tick = &cnt;
        end else begin : g_ext
            logic s1, s2, s3;
            always_ff @(posedge clk) {s3, s2, s1} <= clr_n ? {s2, s1, scan_clk} : 3'b000;
            assign tick = s2 & ~s3;
        end
    endgenerate
    logic [IW-1:0]           idx, nidx;
    logic [4*NUM_DIGITS-1:0] sh_val, cur_val;
    logic [NUM_DIGITS-1:0]   sh_dp, sh_blank, cur_dp, cur_blank, onehot;
    logic                    wrap, lz, dark;
    logic [3:0]              nib;
    logic [6:0]              hex;
    // The slot being entered at a wrap renders from the live inputs it is latching.
    always_comb begin
        nidx      = idx == LAST ? '0 : idx + 1'b1;
        wrap      = nidx == '0;
        cur_val   = wrap ? value : sh_val;
        cur_dp    = wrap ? dp_in : sh_dp;
        cur_blank = wrap ? blank : sh_blank;
        nib       = cur_val[4*nidx +: 4];
        onehot    = '0;
        onehot[nidx] = 1'b1;
        lz        = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        for (int k = 1; k < NUM_DIGITS; k++)
            if (nidx == IW'(k) && (cur_val >> (4*k)) == '0) lz = 1'b1;
`endif
        dark      = cur_blank[nidx] | lz;
    end
    seg7_hex_decode u_dec (.nib(nib), .seg(hex));
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            idx      <= LAST;
            sh_val   <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            an       <= '1;
            seg      <= SEG_OFF;
            dp       <= 1'b1;
        end else if (tick) begin
            idx <= nidx;
            if (wrap) begin
                sh_val   <= value;
                sh_dp    <= dp_in;
                sh_blank <= blank;
            end
            an  <= dark ? '1 : ~onehot;
            seg <= dark ? SEG_OFF : hex;
            dp  <= dark | ~cur_dp[nidx];
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for internal-tick and external-tick driver instances.
module tb_seg7_scan_driver;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif
    localparam logic [11:0] DARK = 12'hFFF;
    typedef struct { int when; logic [11:0] o; } ent_t;
    logic clk = 1'b0, free_sc = 1'b0;
    logic clr_n, ext_clr_n, ext_sc, tog_en, int_on, scan_clk;
    logic [15:0] value, evalue;
    logic [3:0]  dp_in, blank, edp, eblank;
    logic [3:0]  i_an, e_an;
    logic [6:0]  i_seg, e_seg;
    logic        i_dp, e_dp;
    int cyc = 0, tcyc = 0, n_chk = 0, n_fail = 0;
    logic [11:0] cur = DARK, prev = DARK;
    logic [11:0] iq[$];
    ent_t eq[$];
    ent_t ee;
    always #5 clk = ~clk;
    always begin
        repeat (10) @(negedge clk);
        free_sc = ~free_sc;
    end
    assign scan_clk = tog_en ? free_sc : ext_sc;
    always @(posedge clk) begin
        tcyc <= tcyc + 1;
        cyc  <= clr_n ? cyc + 1 : 0;
    end
    seg7_scan_driver #(.NUM_DIGITS(4), .USE_INT_TICK(1), .TICK_DIV(4)) u_int (
        .clk(clk), .clr_n(clr_n), .scan_clk(scan_clk), .value(value), .dp_in(dp_in),
        .blank(blank), .an(i_an), .seg(i_seg), .dp(i_dp));
    seg7_scan_driver #(.NUM_DIGITS(4), .USE_INT_TICK(0), .TICK_DIV(17)) u_ext (
        .clk(clk), .clr_n(ext_clr_n), .scan_clk(scan_clk), .value(evalue), .dp_in(edp),
        .blank(eblank), .an(e_an), .seg(e_seg), .dp(e_dp));
    function automatic logic [11:0] o(input logic [3:0] a, input logic [6:0] s, input logic d);
        return {a, s, d};
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask
    task automatic wait_cyc(input int n);
        do @(negedge clk); while (cyc != n);
    endtask
    task automatic epush(input logic [11:0] v);
        ent_t t;
        t.when = tcyc + 3;
        t.o = v;
        eq.push_back(t);
    endtask
    // Internal instance ticks every 16 cycles; between ticks outputs must hold.
    always @(negedge clk) if (int_on) begin
        if (cyc != 0 && cyc % 16 == 0) begin
            if (iq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL int_queue: tick at cycle %0d with no expectation", cyc);
            end else begin
                cur = iq.pop_front();
                chk("int_tick", {i_an, i_seg, i_dp}, cur);
            end
        end else chk("int_hold", {i_an, i_seg, i_dp}, cur);
    end
    always @(negedge clk) if ({e_an, e_seg, e_dp} !== prev) begin
        prev = {e_an, e_seg, e_dp};
        if (eq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL ext_queue: unexpected output change %h at cycle %0d", prev, tcyc);
        end else begin
            ee = eq.pop_front();
            chk("ext_time", tcyc, ee.when);
            chk("ext_out", prev, ee.o);
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        clr_n = 0; ext_clr_n = 0; tog_en = 1; ext_sc = 0; int_on = 1;
        value = 16'h1234; dp_in = 4'b0000; blank = 4'b0000;
        evalue = 16'h5A3C; edp = 4'b0001; eblank = 4'b0000;
        iq.push_back(o(4'b1110, 7'b0011001, 1));
        iq.push_back(o(4'b1101, 7'b0110000, 1));
        iq.push_back(o(4'b1011, 7'b0100100, 1));
        iq.push_back(o(4'b0111, 7'b1111001, 1));
        iq.push_back(o(4'b1110, 7'b0011001, 1));
        iq.push_back(o(4'b1101, 7'b0110000, 1));
        repeat (10) @(negedge clk);
        clr_n = 1;
        wait_cyc(96);
        value = 16'hABCD;
        iq.push_back(o(4'b1011, 7'b0100100, 1));
        iq.push_back(o(4'b0111, 7'b1111001, 1));
        iq.push_back(o(4'b1110, 7'b0100001, 1));
        iq.push_back(o(4'b1101, 7'b1000110, 1));
        iq.push_back(o(4'b1011, 7'b0000011, 1));
        iq.push_back(o(4'b0111, 7'b0001000, 1));
        wait_cyc(192);
        blank = 4'b1000; dp_in = 4'b0010;
        iq.push_back(o(4'b1110, 7'b0100001, 1));
        iq.push_back(o(4'b1101, 7'b1000110, 0));
        iq.push_back(o(4'b1011, 7'b0000011, 1));
        iq.push_back(DARK);
        wait_cyc(256);
        value = 16'h0050; blank = 4'b0000; dp_in = 4'b0000;
        iq.push_back(o(4'b1110, 7'b1000000, 1));
        iq.push_back(o(4'b1101, 7'b0010010, 1));
        iq.push_back(LZ ? DARK : o(4'b1011, 7'b1000000, 1));
        iq.push_back(LZ ? DARK : o(4'b0111, 7'b1000000, 1));
        wait_cyc(320);
        value = 16'h0000;
        iq.push_back(o(4'b1110, 7'b1000000, 1));
        iq.push_back(LZ ? DARK : o(4'b1101, 7'b1000000, 1));
        iq.push_back(LZ ? DARK : o(4'b1011, 7'b1000000, 1));
        iq.push_back(LZ ? DARK : o(4'b0111, 7'b1000000, 1));
        wait_cyc(385);
        int_on = 0;
        tog_en = 0;
        repeat (5) @(negedge clk);
        ext_clr_n = 1;
        repeat (5) @(negedge clk);
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            ext_sc = 1;
            case (r)
                0, 4: epush(o(4'b1110, 7'b1000110, 0));
                1: epush(o(4'b1101, 7'b0110000, 1));
                2: epush(o(4'b1011, 7'b0001000, 1));
                default: epush(o(4'b0111, 7'b0010010, 1));
            endcase
            repeat (10) @(negedge clk);
            ext_sc = 0;
            repeat (9) @(negedge clk);
        end
        // Reset lands on the very edge that would consume the tick.
        @(negedge clk);
        ext_sc = 1;
        epush(DARK);
        repeat (2) @(negedge clk);
        ext_clr_n = 0;
        repeat (8) @(negedge clk);
        ext_sc = 0;
        repeat (5) @(negedge clk);
        ext_clr_n = 1;
        repeat (5) @(negedge clk);
        ext_sc = 1;
        epush(o(4'b1110, 7'b1000110, 0));
        repeat (10) @(negedge clk);
        ext_sc = 0;
        repeat (10) @(negedge clk);
        chk("int_queue_drained", iq.size(), 0);
        chk("ext_queue_drained", eq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Consumes the slow divided scan clock produced by the shared clock divider and drives the multiplexed 4-digit, 7-segment display on the board.
- Converts the scan clock into a single-cycle enable in the master clock domain and rotates the digit anode.
- Per digit slot, drives the hex-decoded segments and decimal point.
- Latches the display value once per full scan frame so digits never show a torn value.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; value width is 4*NUM_DIGITS.
- USE_INT_TICK, 0, 1 = generate the scan tick from an internal prescaler and ignore scan_clk; 0 = derive the tick from scan_clk.
- TICK_DIV, 17, prescaler width when USE_INT_TICK=1; tick period is 2^TICK_DIV clk cycles.

Ports:
- clk  in  1  master clock (50 MHz); the only clock.
- clr_n  in  1  synchronous, active-low reset, sampled on posedge clk.
- scan_clk  in  1  divided scan clock (~381 Hz); treated as a level and sampled in the clk domain.
- value  in  4*NUM_DIGITS  hex value to display; nibble k drives digit k, with digit 0 rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit; 1 = lit.
- blank  in  NUM_DIGITS  per-digit blank; 1 = digit dark.
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low or all-ones.
- seg  out  7  segments, active-low; bit6..bit0 = g,f,e,d,c,b,a.
- dp  out  1  decimal point, active-low.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on clr_n; reset wins over any simultaneous tick.
- Reset values:
  - an = all ones, seg = 7'h7F, dp = 1.
  - Digit index = NUM_DIGITS-1.
  - Shadow value/dp/blank = 0.
  - Sync flops and prescaler = 0.
- Tick generation, external (USE_INT_TICK=0):
  - Two-flop synchronizer on scan_clk, then a third delay flop.
  - tick = s2 & ~s3, exactly one clk cycle per scan_clk rising edge. Falling edges produce nothing.
  - If scan_clk is first sampled high at edge N, the outputs change at edge N+2.
- Tick generation, internal (USE_INT_TICK=1):
  - TICK_DIV-bit free-running counter; tick is asserted while the counter is all ones.
  - First tick occurs 2^TICK_DIV - 1 cycles after reset release.
- On each tick:
  - idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1.
  - an, seg and dp are registered from the new idx at the same edge.
- Frame latch: at the edge where idx wraps to 0, value, dp_in and blank are captured into the shadow registers. Digit 0 is rendered from those same live inputs at that edge. Other slots render from the shadow registers only.
- Because reset sets idx = NUM_DIGITS-1, the first tick always loads the shadow and shows digit 0.
- Slot rendering:
  - If the shadow blank bit is set: an = all ones, seg = 7'h7F, dp = 1.
  - Otherwise: an = ~(1<<idx), seg = hexdecode(nibble), dp = ~dp bit.
- Hex decode (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- No tick: all outputs hold.
- Input changes between frame latches are invisible until the next wrap.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: digit k ≥ 1 is forced dark (an bit high, seg 7'h7F, dp 1) when nibbles k..NUM_DIGITS-1 of the shadow value are all zero. Digit 0 is never suppressed by this rule.
- Undefined: zeros display normally; only the blank bits darken digits.

Decomposition:
- Package seg7_pkg holds:
  - SEG_OFF = 7'h7F.
  - Default NUM_DIGITS.
  - The 16-entry active-low hex segment constant table.
- Sub-module: seg7_hex_decode, a combinational 4-bit to 7-bit lookup using the package table, instantiated once on the selected nibble.
- Tick sync/edge detect stays inline.

Test Plan:
- Reset: hold clr_n=0 with scan_clk toggling -> an=1111, seg=7F, dp=1 throughout. After release, no output change until the first tick.
- Internal tick, USE_INT_TICK=1, TICK_DIV=4, value=16'h1234:
  - First tick -> an=1110, seg=0011001.
  - 16 cycles later -> an=1101, seg=0110000.
  - Then an=1011 (2), then an=0111 (1), then back to an=1110.
- Tearing: change value 1234->ABCD while digit 1 is active -> digits 2,3 still show 2,1. After the wrap, digit 0 = D (0100001) and all digits show ABCD.
- Blank and dp: blank=4'b1000, dp_in=4'b0010 -> the digit-3 slot has an=1111 and seg=7F; dp=0 only in the digit-1 slot.
- External tick: scan_clk period 20 clk, USE_INT_TICK=0 -> an advances exactly 2 edges after scan_clk is sampled high, once per rising edge. A reset asserted during a tick cycle yields reset values.
- With SEG7_LEADING_ZERO_BLANK_EN defined:
  - value=16'h0050 -> digits 3,2 dark, digit 1 = 0010010, digit 0 = 1000000.
  - value=0 -> only digit 0 lit.
